// File: rtl/nasti_lite_writer.sv
// nasti_lite_writer: splits one NASTI INCR write burst at a time into single lite writes and merges their responses.
// Optional NASTI_LITE_WRITER_SKIP_EN: slices whose strobe slice is all zero issue no lite write.
module nasti_lite_writer #(
  parameter int ID_WIDTH = 1,
  parameter int ADDR_WIDTH = 12,
  parameter int NASTI_DATA_WIDTH = 64,
  parameter int LITE_DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ID_WIDTH-1:0]           nasti_aw_id,
  input  logic [ADDR_WIDTH-1:0]         nasti_aw_addr,
  input  logic [7:0]                    nasti_aw_len,
  input  logic [2:0]                    nasti_aw_size,
  input  logic [2:0]                    nasti_aw_prot,
  input  logic                          nasti_aw_valid,
  output logic                          nasti_aw_ready,
  input  logic [NASTI_DATA_WIDTH-1:0]   nasti_w_data,
  input  logic [NASTI_DATA_WIDTH/8-1:0] nasti_w_strb,
  input  logic                          nasti_w_valid,
  output logic                          nasti_w_ready,
  output logic [ID_WIDTH-1:0]           nasti_b_id,
  output logic [1:0]                    nasti_b_resp,
  output logic                          nasti_b_valid,
  input  logic                          nasti_b_ready,
  output logic [ADDR_WIDTH-1:0]         lite_aw_addr,
  output logic [2:0]                    lite_aw_prot,
  output logic                          lite_aw_valid,
  input  logic                          lite_aw_ready,
  output logic [LITE_DATA_WIDTH-1:0]    lite_w_data,
  output logic [LITE_DATA_WIDTH/8-1:0]  lite_w_strb,
  output logic                          lite_w_valid,
  input  logic                          lite_w_ready,
  input  logic [1:0]                    lite_b_resp,
  input  logic                          lite_b_valid,
  output logic                          lite_b_ready
);
  localparam int LB = LITE_DATA_WIDTH / 8;
  localparam int NB = NASTI_DATA_WIDTH / 8;
  localparam int NS = NB / LB;
  localparam int LLB = $clog2(LB);
  localparam int LNB = $clog2(NB);
  localparam int SW = $clog2(NS) + 1;
`ifdef NASTI_LITE_WRITER_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, BEAT, SEND, WAITB, RESP} state_t;

  function automatic int sidx(input logic [ADDR_WIDTH-1:0] a);
    return int'((a >> LLB) % NS);
  endfunction

  function automatic logic [LB-1:0] strb_sl(input logic [NB-1:0] s, input logic [ADDR_WIDTH-1:0] a);
    return s[sidx(a)*LB +: LB];
  endfunction

  state_t                        state;
  logic [ID_WIDTH-1:0]           id_r;
  logic [ADDR_WIDTH-1:0]         lite_addr, step, nxt_addr;
  logic [7:0]                    len_r, beat_cnt;
  logic [2:0]                    size_r, prot_r;
  logic [NASTI_DATA_WIDTH-1:0]   data_r;
  logic [NB-1:0]                 strb_r;
  logic [SW-1:0]                 slice_cnt, r_last;
  logic [1:0]                    resp_r;
  logic                          skip_r, aw_hs, w_hs, lb_hs, nb_hs, send_done, adv, ent_skip, nxt_skip;

  assign lite_aw_addr = lite_addr;
  assign lite_aw_prot = prot_r;
  assign lite_w_data  = data_r[sidx(lite_addr)*LITE_DATA_WIDTH +: LITE_DATA_WIDTH];
  assign lite_w_strb  = strb_sl(strb_r, lite_addr);
  assign nasti_b_id   = id_r;
  assign nasti_b_resp = resp_r;

  always_comb begin
    aw_hs     = nasti_aw_valid && nasti_aw_ready;
    w_hs      = nasti_w_valid && nasti_w_ready;
    lb_hs     = lite_b_valid && lite_b_ready;
    nb_hs     = nasti_b_valid && nasti_b_ready;
    step      = (size_r > 3'(LLB)) ? ADDR_WIDTH'(LB) : ADDR_WIDTH'(1) << size_r;
    r_last    = (size_r > 3'(LLB)) ? SW'((1 << (size_r - 3'(LLB))) - 1) : '0;
    nxt_addr  = lite_addr + step;
    send_done = (!lite_aw_valid || lite_aw_ready) && (!lite_w_valid || lite_w_ready);
    adv       = (state == SEND && send_done && skip_r) || (state == WAITB && lb_hs);
    ent_skip  = SKIP_EN && strb_sl(nasti_w_strb, lite_addr) == '0;
    nxt_skip  = SKIP_EN && strb_sl(strb_r, nxt_addr) == '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      id_r <= '0;
      lite_addr <= '0;
      len_r <= '0;
      beat_cnt <= '0;
      size_r <= '0;
      prot_r <= '0;
      data_r <= '0;
      strb_r <= '0;
      slice_cnt <= '0;
      resp_r <= '0;
      skip_r <= 1'b0;
      nasti_aw_ready <= 1'b0;
      nasti_w_ready <= 1'b0;
      nasti_b_valid <= 1'b0;
      lite_aw_valid <= 1'b0;
      lite_w_valid <= 1'b0;
      lite_b_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          nasti_aw_ready <= !aw_hs;
          resp_r <= '0;
          if (aw_hs) begin
            id_r <= nasti_aw_id;
            lite_addr <= nasti_aw_addr;
            len_r <= nasti_aw_len;
            size_r <= nasti_aw_size;
            prot_r <= nasti_aw_prot;
            beat_cnt <= '0;
            slice_cnt <= '0;
            nasti_w_ready <= 1'b1;
            state <= BEAT;
          end
        end
        BEAT: if (w_hs) begin
          nasti_w_ready <= 1'b0;
          data_r <= nasti_w_data;
          strb_r <= nasti_w_strb;
          lite_aw_valid <= !ent_skip;
          lite_w_valid <= !ent_skip;
          skip_r <= ent_skip;
          state <= SEND;
        end
        SEND: begin
          if (lite_aw_ready) lite_aw_valid <= 1'b0;
          if (lite_w_ready) lite_w_valid <= 1'b0;
          if (send_done && !skip_r) begin
            lite_b_ready <= 1'b1;
            state <= WAITB;
          end
        end
        WAITB: if (lb_hs) begin
          lite_b_ready <= 1'b0;
          resp_r <= (lite_b_resp > resp_r) ? lite_b_resp : resp_r;
        end
        RESP: if (nb_hs) begin
          nasti_b_valid <= 1'b0;
          nasti_aw_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // one slice finished (or skipped): next slice, next beat or final response
      if (adv) begin
        lite_addr <= nxt_addr;
        if (slice_cnt != r_last) begin
          slice_cnt <= slice_cnt + 1'b1;
          lite_aw_valid <= !nxt_skip;
          lite_w_valid <= !nxt_skip;
          skip_r <= nxt_skip;
          state <= SEND;
        end else if (beat_cnt != len_r) begin
          beat_cnt <= beat_cnt + 1'b1;
          slice_cnt <= '0;
          nasti_w_ready <= 1'b1;
          state <= BEAT;
        end else begin
          nasti_b_valid <= 1'b1;
          state <= RESP;
        end
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (!rst && aw_hs && nasti_aw_size > 3'(LNB))
      $fatal(1, "nasti_lite_writer: aw size %0d wider than data bus", nasti_aw_size);
`endif
endmodule

// File: tb/tb_nasti_lite_writer.sv
// tb_nasti_lite_writer: randomized scoreboard bench for nasti_lite_writer (64-bit NASTI, 32-bit lite).
module tb_nasti_lite_writer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:0]  nasti_aw_id;
  logic [11:0] nasti_aw_addr;
  logic [7:0]  nasti_aw_len;
  logic [2:0]  nasti_aw_size, nasti_aw_prot;
  logic        nasti_aw_valid, nasti_aw_ready;
  logic [63:0] nasti_w_data;
  logic [7:0]  nasti_w_strb;
  logic        nasti_w_valid, nasti_w_ready;
  logic [0:0]  nasti_b_id;
  logic [1:0]  nasti_b_resp;
  logic        nasti_b_valid, nasti_b_ready;
  logic [11:0] lite_aw_addr;
  logic [2:0]  lite_aw_prot;
  logic        lite_aw_valid, lite_aw_ready;
  logic [31:0] lite_w_data;
  logic [3:0]  lite_w_strb;
  logic        lite_w_valid, lite_w_ready;
  logic [1:0]  lite_b_resp;
  logic        lite_b_valid, lite_b_ready;

  always #5 clk = ~clk;

  nasti_lite_writer dut (
    .clk(clk), .rst(rst),
    .nasti_aw_id(nasti_aw_id), .nasti_aw_addr(nasti_aw_addr), .nasti_aw_len(nasti_aw_len),
    .nasti_aw_size(nasti_aw_size), .nasti_aw_prot(nasti_aw_prot),
    .nasti_aw_valid(nasti_aw_valid), .nasti_aw_ready(nasti_aw_ready),
    .nasti_w_data(nasti_w_data), .nasti_w_strb(nasti_w_strb),
    .nasti_w_valid(nasti_w_valid), .nasti_w_ready(nasti_w_ready),
    .nasti_b_id(nasti_b_id), .nasti_b_resp(nasti_b_resp),
    .nasti_b_valid(nasti_b_valid), .nasti_b_ready(nasti_b_ready),
    .lite_aw_addr(lite_aw_addr), .lite_aw_prot(lite_aw_prot),
    .lite_aw_valid(lite_aw_valid), .lite_aw_ready(lite_aw_ready),
    .lite_w_data(lite_w_data), .lite_w_strb(lite_w_strb),
    .lite_w_valid(lite_w_valid), .lite_w_ready(lite_w_ready),
    .lite_b_resp(lite_b_resp), .lite_b_valid(lite_b_valid), .lite_b_ready(lite_b_ready)
  );

  typedef struct packed { logic [11:0] addr; logic [2:0] prot; } aw_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; } w_t;
  typedef struct packed { logic [0:0] id; logic [1:0] resp; logic [15:0] n; } b_t;

  aw_t        exp_aw[$];
  w_t         exp_w[$];
  b_t         exp_b[$];
  logic [1:0] resp_q[$];
  aw_t        ea;
  w_t         ew;
  b_t         eb;

  int   n_cmp = 0, n_err = 0;
  bit   quiet = 1'b0, arm = 1'b0, got_aw = 1'b0, got_w = 1'b0;
  int   stall = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // lite slave and NASTI B acceptor: random readies, one B per accepted AW+W pair
  initial begin
    bit ah, wh, bh;
    lite_aw_ready = 0; lite_w_ready = 0; lite_b_valid = 0; lite_b_resp = 0; nasti_b_ready = 0;
    forever begin
      @(negedge clk);
      ah = lite_aw_valid && lite_aw_ready;
      wh = lite_w_valid && lite_w_ready;
      bh = lite_b_valid && lite_b_ready;
      @(posedge clk); #1;
      if (rst) begin
        got_aw = 0; got_w = 0; lite_b_valid = 0;
      end else begin
        if (ah) got_aw = 1;
        if (wh) got_w = 1;
        if (bh) lite_b_valid = 0;
        if (got_aw && got_w && !lite_b_valid) begin
          lite_b_valid = 1;
          lite_b_resp = resp_q.size() != 0 ? resp_q.pop_front() : 2'd0;
          got_aw = 0; got_w = 0;
        end
      end
      if (arm && lite_aw_valid) begin stall = 5; arm = 0; end
      if (stall > 0) begin
        lite_aw_ready = 0; lite_w_ready = 1; stall--;
      end else begin
        lite_aw_ready = $urandom_range(0, 2) != 0;
        lite_w_ready = $urandom_range(0, 2) != 0;
      end
      nasti_b_ready = $urandom_range(0, 2) != 0;
    end
  end

  // monitor: pops the scoreboard on every handshake and checks lite protocol rules
  initial begin
    bit prev_pend = 0, aw_done = 0, w_done = 0;
    logic [11:0] prev_addr = '0;
    int lb_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst || quiet) begin
        prev_pend = 0; aw_done = 0; w_done = 0; lb_cnt = 0;
        continue;
      end
      if (prev_pend) chk("lite_aw_stable", {lite_aw_valid, lite_aw_addr}, {1'b1, prev_addr});
      if (aw_done) chk("lite_aw_drop", lite_aw_valid, 0);
      if (w_done) chk("lite_w_drop", lite_w_valid, 0);
      if (lite_aw_valid && lite_aw_ready) begin
        aw_done = 1;
        if (exp_aw.size() == 0) chk("lite_aw_unexpected", 1, 0);
        else begin
          ea = exp_aw.pop_front();
          chk("lite_aw_addr", lite_aw_addr, ea.addr);
          chk("lite_aw_prot", lite_aw_prot, ea.prot);
        end
      end
      if (lite_w_valid && lite_w_ready) begin
        w_done = 1;
        if (exp_w.size() == 0) chk("lite_w_unexpected", 1, 0);
        else begin
          ew = exp_w.pop_front();
          chk("lite_w_data", lite_w_data, ew.data);
          chk("lite_w_strb", lite_w_strb, ew.strb);
        end
      end
      if (lite_b_valid && lite_b_ready) begin
        lb_cnt++; aw_done = 0; w_done = 0;
      end
      if (nasti_b_valid && nasti_b_ready) begin
        if (exp_b.size() == 0) chk("nasti_b_unexpected", 1, 0);
        else begin
          eb = exp_b.pop_front();
          chk("nasti_b_id", nasti_b_id, eb.id);
          chk("nasti_b_resp", nasti_b_resp, eb.resp);
          chk("lite_b_count", lb_cnt, eb.n);
        end
        lb_cnt = 0;
      end
      prev_pend = lite_aw_valid && !lite_aw_ready;
      prev_addr = lite_aw_addr;
    end
  end

  task automatic wait_hs(input bit is_w);
    int n = 0;
    bit hs;
    do begin
      @(negedge clk); n++;
      hs = is_w ? (nasti_w_valid && nasti_w_ready) : (nasti_aw_valid && nasti_aw_ready);
    end while (!hs && n < 2000);
    if (!hs) chk(is_w ? "nasti_w_timeout" : "nasti_aw_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  // reference model: lite address = start + beat*2^size + slice*step, slice picked by address bit 2
  task automatic burst(input logic [0:0] id, input logic [11:0] addr, input int len, input int size,
                       input logic [2:0] prot, input int rmode, input logic [63:0] d0, input bit rstrb);
    int nb = 1 << size;
    int step = nb < 4 ? nb : 4;
    int r = nb > 4 ? nb / 4 : 1;
    int total = (len + 1) * r;
    int n = 0;
    logic [1:0] mx = 0, rs;
    logic [63:0] d;
    logic [7:0] s;
    logic [11:0] la;
    for (int i = 0; i < total; i++) begin
      rs = rmode == 0 ? 2'd0 : rmode == 1 ? (i == 1 ? 2'd2 : 2'd0) : 2'($urandom_range(0, 3));
      resp_q.push_back(rs);
      if (rs > mx) mx = rs;
    end
    exp_b.push_back('{id: id, resp: mx, n: 16'(total)});
    nasti_aw_id = id; nasti_aw_addr = addr; nasti_aw_len = 8'(len);
    nasti_aw_size = 3'(size); nasti_aw_prot = prot; nasti_aw_valid = 1;
    wait_hs(0);
    nasti_aw_valid = 0;
    for (int b = 0; b < len + 1; b++) begin
      d = (b == 0 && d0 != 0) ? d0 : {$urandom, $urandom};
      s = rstrb ? 8'($urandom) : 8'hFF;
      for (int k = 0; k < r; k++) begin
        la = 12'(int'(addr) + b * nb + k * step);
        exp_aw.push_back('{addr: la, prot: prot});
        exp_w.push_back('{data: 32'(d >> (la[2] * 32)), strb: 4'(s >> (la[2] * 4))});
      end
      nasti_w_data = d; nasti_w_strb = s; nasti_w_valid = 1;
      wait_hs(1);
      nasti_w_valid = 0;
    end
    while (exp_b.size() != 0 && n < 20000) begin @(negedge clk); n++; end
    if (exp_b.size() != 0) begin
      chk("nasti_b_timeout", 1, 0);
      exp_b.delete(); exp_aw.delete(); exp_w.delete(); resp_q.delete();
    end
    chk("burst_drained", 64'(exp_aw.size() + exp_w.size()), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int sz, ln;
    nasti_aw_id = 0; nasti_aw_addr = 0; nasti_aw_len = 0; nasti_aw_size = 0; nasti_aw_prot = 0;
    nasti_aw_valid = 0; nasti_w_data = 0; nasti_w_strb = 0; nasti_w_valid = 0;
    repeat (3) @(negedge clk);
    chk("reset_handshakes", {nasti_aw_ready, nasti_w_ready, nasti_b_valid, lite_aw_valid, lite_w_valid, lite_b_ready}, 0);
    chk("reset_fields", {nasti_b_id, nasti_b_resp, lite_aw_addr, lite_aw_prot}, 0);
    rst = 0;
    @(negedge clk);
    chk("aw_ready_after_reset", nasti_aw_ready, 1);
    @(posedge clk); #1;
    burst(1, 12'h100, 0, 3, 3'h5, 0, 64'h1122334455667788, 0);
    burst(0, 12'h200, 3, 2, 3'h0, 0, 64'h0, 0);
    burst(0, 12'h200, 3, 2, 3'h2, 1, 64'h0, 0);
    arm = 1;
    burst(1, 12'h300, 1, 3, 3'h3, 2, 64'h0, 1);
    burst(1, 12'hFF8, 1, 3, 3'h1, 2, 64'h0, 1);
    burst(0, 12'h000, 255, 3, 3'h6, 2, 64'h0, 1);
    for (int i = 0; i < 20; i++) begin
      sz = $urandom_range(0, 3);
      ln = $urandom_range(0, 7);
      burst(1'($urandom), 12'($urandom) & ~12'((1 << sz) - 1), ln, sz, 3'($urandom), 2, 64'h0, 1);
    end
    quiet = 1;
    nasti_aw_addr = 12'h400; nasti_aw_len = 3; nasti_aw_size = 3; nasti_aw_valid = 1;
    wait_hs(0);
    nasti_aw_valid = 0;
    nasti_w_data = {$urandom, $urandom}; nasti_w_strb = 8'hFF; nasti_w_valid = 1;
    wait_hs(1);
    nasti_w_valid = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1;
    #1 chk("midburst_reset_valids", {nasti_aw_ready, nasti_w_ready, nasti_b_valid, lite_aw_valid, lite_w_valid, lite_b_ready}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("midburst_aw_ready", nasti_aw_ready, 1);
    chk("midburst_no_b", nasti_b_valid, 0);
    resp_q.delete(); exp_aw.delete(); exp_w.delete(); exp_b.delete();
    quiet = 0;
    @(posedge clk); #1;
    burst(1, 12'h7F0, 2, 3, 3'h7, 2, 64'h0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/nasti_lite_writer.md
Name:
nasti_lite_writer

Overview:
Write-direction NASTI-to-NASTI-lite converter: accepts one INCR write burst at a time, splits each NASTI beat into LITE_DATA_WIDTH-wide lite AW/W writes, collects every lite B, and returns a single merged NASTI B per burst.

Parameters:
ID_WIDTH, 1, NASTI AW/B id width
ADDR_WIDTH, 12, address width on both sides
NASTI_DATA_WIDTH, 64, NASTI W data width (>= LITE_DATA_WIDTH, power of 2)
LITE_DATA_WIDTH, 32, lite W data width (32 or 64 only)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
nasti_aw_id  in  ID_WIDTH  burst id
nasti_aw_addr  in  ADDR_WIDTH  burst start address, aligned to size
nasti_aw_len  in  8  beats-1
nasti_aw_size  in  3  log2 bytes per beat
nasti_aw_prot  in  3  protection, forwarded to lite
nasti_aw_valid  in  1  AW valid
nasti_aw_ready  out  1  AW ready
nasti_w_data  in  NASTI_DATA_WIDTH  beat data
nasti_w_strb  in  NASTI_DATA_WIDTH/8  beat byte strobes
nasti_w_valid  in  1  W valid
nasti_w_ready  out  1  W ready
nasti_b_id  out  ID_WIDTH  echoed burst id
nasti_b_resp  out  2  merged response
nasti_b_valid  out  1  B valid
nasti_b_ready  in  1  B ready
lite_aw_addr  out  ADDR_WIDTH  lite write address
lite_aw_prot  out  3  captured nasti_aw_prot
lite_aw_valid  out  1  lite AW valid
lite_aw_ready  in  1  lite AW ready
lite_w_data  out  LITE_DATA_WIDTH  lite data slice
lite_w_strb  out  LITE_DATA_WIDTH/8  lite strobe slice
lite_w_valid  out  1  lite W valid
lite_w_ready  in  1  lite W ready
lite_b_resp  in  2  lite response
lite_b_valid  in  1  lite B valid
lite_b_ready  out  1  lite B ready

Behaviour:
- Reset (rst=1, async): state IDLE, all counters, accumulated resp and captured fields 0; every valid/ready output 0; nasti_aw_ready rises the first cycle after rst deasserts. Reset mid-burst aborts silently: no B issued, partially issued lite writes are abandoned.
- FSM: IDLE -(aw handshake, capture id/addr/len/size/prot)-> BEAT -(w handshake, capture data/strb)-> SEND -(lite AW and W both accepted)-> WAITB -(lite b handshake)-> SEND (more slices in beat) | BEAT (more beats) | RESP -(nasti b handshake)-> IDLE. Exactly one lite write outstanding at a time.
- Readies: nasti_aw_ready=1 only in IDLE; nasti_w_ready=1 only in BEAT; lite_b_ready=1 only in WAITB. Each state's valid/ready is registered, asserted the cycle after entry.
- SEND: lite_aw_valid and lite_w_valid both assert on entry; each drops independently on its own handshake and is never reasserted for the same slice. Payload stays stable while valid.
- Slicing: R = size > log2(LITE bytes) ? 2^(size - log2(LITE bytes)) : 1 slices per beat; step = min(2^size, LITE bytes). Beat address = start + beat*2^size. Lite addr = beat address + slice*step, wrapping mod 2^ADDR_WIDTH. Slice index into the beat = addr[log2(NASTI bytes)-1 : log2(LITE bytes)] of the lite address (0 when widths are equal). Data and strb slices are taken at that index, unmodified.
- Response: accumulated resp = numeric max of all lite_b_resp in the burst, cleared in IDLE; it drives nasti_b_resp with nasti_b_id = captured id.
- Completion: after slice R-1 of beat len, go to RESP. len=255 with R=2 gives 512 lite writes; counters must not overflow.
- Simulation-only check: fatal when an aw handshake has size > log2(NASTI bytes).

Optional Feature:
NASTI_LITE_WRITER_SKIP_EN: when defined, a slice whose strobe slice is all zero issues no lite AW/W/B. SEND advances directly as if an OKAY were received. When undefined, every slice is issued regardless of strobes.

Test Plan:
64/32, aw addr 0x100 len 0 size 3 id 1, w data 0x1122334455667788 strb 0xFF -> lite (0x100, 0x55667788, 0xF) then (0x104, 0x11223344, 0xF); b id 1 resp 0.
aw addr 0x200 len 3 size 2 -> 4 lite writes at 0x200/0x204/0x208/0x20C; data from the lower/upper/lower/upper beat half.
Same burst with lite_b_resp=2 on the 2nd write only -> single nasti B, resp 2, after all 4 lite Bs.
lite_aw_ready=0 for 5 cycles, lite_w_ready=1 -> W accepted once, lite_w_valid drops, lite AW payload stable, exactly one lite B wait; rst pulse mid-burst -> all valids 0, nasti_aw_ready=1 the next cycle.
